cu_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer for the RV32I core. It replaces the fixed four-phase control state machine with a handshaked sequencer that:
- waits on instruction and data bus acknowledges;
- adds a dedicated memory phase for loads and stores;
- can fuse writeback into execute for non-memory instructions;
- traps on illegal opcodes and bus timeouts instead of halting simulation.

It drives the same strobes (fetch, IR load, PC enable, writeback) to the datapath, sits beside the opcode/ALU decoder, and keeps a retired-instruction counter.

---
 rtl/cu_sequencer_if.sv | 25 ++
 rtl/cu_sequencer.sv | 146 ++++++++++++++
 tb/tb_cu_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_sequencer_if.sv
// Instruction and data bus handshake between the control sequencer and the memory side.
// A request stays high until an ack is sampled in a non-stalled cycle; ack must stay high until then.
interface cu_sequencer_if;
    logic ibus_req;
    logic ibus_ack;
    logic dbus_req;
    logic dbus_we;
    logic dbus_ack;

    modport master (
        output ibus_req,
        output dbus_req,
        output dbus_we,
        input  ibus_ack,
        input  dbus_ack
    );

    modport slave (
        input  ibus_req,
        input  dbus_req,
        input  dbus_we,
        output ibus_ack,
        output dbus_ack
    );
endinterface

// File: rtl/cu_sequencer.sv
// Handshaked multi-cycle control sequencer for the RV32I core: fetch, IR load, execute,
// optional memory phase and writeback, trapping on illegal opcodes and bus timeouts.
module cu_sequencer #(
    parameter int TIMEOUT = 16,
    parameter bit FUSE_WB = 1'b0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             stall,
    input  logic             debug_wait,
    input  logic             trap_clear,
    cu_sequencer_if.master   bus,
    output logic             load_ir,
    output logic             en_pc_counter,
    output logic             write_back_stage,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD_IR = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IBUS    = 2'd2;
    localparam logic [1:0] CAUSE_DBUS    = 2'd3;

    // A zero TIMEOUT still needs a one-bit counter; the compare is disabled instead.
    localparam int            TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN   = (TIMEOUT > 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [TW-1:0] wait_cnt;
    logic          legal;
    logic          is_store;
    logic          is_mem;
    logic          fuse_now;
    logic          timed_out;

    always_comb begin
        is_store  = (opcode == OP_STORE);
        is_mem    = (opcode == OP_LOAD) || is_store;
        legal     = opcode inside {OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        fuse_now  = FUSE_WB && legal && !is_mem;
        timed_out = TO_EN && (wait_cnt == TO_LAST);
    end

    // TRAP is checked ahead of stall so a stalled pipeline can still be un-trapped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
            retired    <= '0;
        end else if (state == S_TRAP) begin
            if (trap_clear) begin
                state      <= S_IDLE;
                trap_cause <= 2'd0;
            end
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    if (!debug_wait) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.ibus_ack) begin
                        state <= S_LOAD_IR;
                    end else if (timed_out) begin
                        state      <= S_TRAP;
                        trap_cause <= CAUSE_IBUS;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_LOAD_IR: state <= S_EXEC;
                S_EXEC: begin
                    if (!legal) begin
                        state      <= S_TRAP;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else if (is_mem) begin
                        state    <= S_MEM;
                        wait_cnt <= '0;
                    end else if (FUSE_WB) begin
                        state    <= debug_wait ? S_IDLE : S_FETCH;
                        wait_cnt <= '0;
                        retired  <= retired + CNT_W'(1);
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dbus_ack) begin
                        state <= S_WB;
                    end else if (timed_out) begin
                        state      <= S_TRAP;
                        trap_cause <= CAUSE_DBUS;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_WB: begin
                    state    <= debug_wait ? S_IDLE : S_FETCH;
                    wait_cnt <= '0;
                    retired  <= retired + CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are masked by stall so each fires once per instruction; requests stay up.
    assign state_o          = state;
    assign bus.ibus_req     = (state == S_FETCH);
    assign bus.dbus_req     = (state == S_MEM);
    assign bus.dbus_we      = (state == S_MEM) && is_store;
    assign load_ir          = !stall && (state == S_LOAD_IR);
    assign en_pc_counter    = !stall && (state == S_EXEC) && legal;
    assign write_back_stage = !stall && ((state == S_WB) || ((state == S_EXEC) && fuse_now));
    assign trap             = (state == S_TRAP);

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: directed scenarios plus randomized instructions with random bus
// waits and stalls, checked against a per-instruction phase-length model.
`timescale 1ns/1ps
module tb_cu_sequencer;

    localparam int TO  = 4;
    localparam int CW  = 32;
    localparam int CWB = 4;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Unit A: separate writeback, short timeout
    logic [6:0]    opcode;
    logic          stall, debug_wait, trap_clear;
    logic          load_ir, en_pc_counter, write_back_stage, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired;
    logic [2:0]    state_o;
    cu_sequencer_if bus_a ();

    cu_sequencer #(.TIMEOUT(TO), .FUSE_WB(1'b0), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .stall(stall), .debug_wait(debug_wait),
        .trap_clear(trap_clear), .bus(bus_a), .load_ir(load_ir),
        .en_pc_counter(en_pc_counter), .write_back_stage(write_back_stage), .trap(trap),
        .trap_cause(trap_cause), .retired(retired), .state_o(state_o)
    );

    // Unit B: fused writeback, narrow retire counter
    logic [6:0]     b_opcode;
    logic           b_stall, b_debug_wait, b_trap_clear;
    logic           b_load_ir, b_en_pc, b_wb, b_trap;
    logic [1:0]     b_cause;
    logic [CWB-1:0] b_retired;
    logic [2:0]     b_state;
    cu_sequencer_if bus_b ();

    cu_sequencer #(.TIMEOUT(TO), .FUSE_WB(1'b1), .CNT_W(CWB)) dut_b (
        .clk(clk), .rst(rst), .opcode(b_opcode), .stall(b_stall), .debug_wait(b_debug_wait),
        .trap_clear(b_trap_clear), .bus(bus_b), .load_ir(b_load_ir),
        .en_pc_counter(b_en_pc), .write_back_stage(b_wb), .trap(b_trap),
        .trap_cause(b_cause), .retired(b_retired), .state_o(b_state)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_ret  = '0;
    logic [CW-1:0] exp_q[$];
    logic [6:0]    legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                     7'b0010111};
    logic [2:0]    pat [4] = '{3'd1, 3'd2, 3'd3, 3'd5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Runs one instruction on unit A starting in FETCH. Phase lengths come from the wait
    // rules: a bus phase lasts delay+1 non-stalled cycles, or TO cycles ending in a trap.
    task automatic run_instr(input logic [6:0] op, input int di, input int dd,
                             input int stall_pct, input int stall_at, input int stall_len,
                             output int cycles);
        bit lg, mem, st, ftrap, mtrap, s, in_f, in_m;
        int f_n, m_n, mem_at, total, cause, ns, left;
        int o_ld, o_pc, o_wb, o_stb, o_ir, e_ir, o_dr, e_dr, o_we, e_we;
        lg     = is_legal(op);
        mem    = lg && (op == OP_LOAD || op == OP_STORE);
        st     = (op == OP_STORE);
        f_n    = (di < TO) ? di + 1 : TO;
        ftrap  = (di >= TO);
        m_n    = (dd < TO) ? dd + 1 : TO;
        mtrap  = mem && !ftrap && (dd >= TO);
        mem_at = f_n + 2;
        if (ftrap)      begin total = f_n;                        cause = 2; end
        else if (!lg)   begin total = f_n + 2;                    cause = 1; end
        else if (mem)   begin total = mem_at + m_n + (mtrap ? 0 : 1); cause = mtrap ? 3 : 0; end
        else            begin total = f_n + 3;                    cause = 0; end
        if (cause == 0) exp_ret = exp_ret + 1;
        exp_q.push_back(exp_ret);

        opcode = op;
        chk("start_in_fetch", state_o, 1);
        ns = 0; cycles = 0; left = stall_len;
        o_ld = 0; o_pc = 0; o_wb = 0; o_stb = 0;
        o_ir = 0; e_ir = 0; o_dr = 0; e_dr = 0; o_we = 0; e_we = 0;
        while (ns < total && cycles < 400) begin
            in_f = (ns < f_n);
            in_m = mem && (ns >= mem_at) && (ns < mem_at + m_n);
            if (stall_at == ns && left > 0) begin
                s = 1'b1;
                left--;
            end else begin
                s = ($urandom_range(99) < stall_pct);
            end
            stall          = s;
            trap_clear     = ($urandom_range(3) == 0);
            bus_a.ibus_ack = in_f && ((ns >= di) || (s && $urandom_range(1) == 1));
            bus_a.dbus_ack = in_m && ((ns - mem_at >= dd) || (s && $urandom_range(1) == 1));
            #1;
            o_ld  += int'(load_ir);
            o_pc  += int'(en_pc_counter);
            o_wb  += int'(write_back_stage);
            if (s) o_stb += int'(load_ir | en_pc_counter | write_back_stage);
            o_ir  += int'(bus_a.ibus_req);
            e_ir  += int'(in_f);
            o_dr  += int'(bus_a.dbus_req);
            e_dr  += int'(in_m);
            o_we  += int'(bus_a.dbus_we);
            e_we  += int'(in_m && st);
            if (!s) ns++;
            cycles++;
            tick();
        end
        stall = 1'b0; trap_clear = 1'b0; bus_a.ibus_ack = 1'b0; bus_a.dbus_ack = 1'b0;

        chk("instr_done", ns, total);
        chk("load_ir_pulses", o_ld, ftrap ? 0 : 1);
        chk("pc_pulses", o_pc, (!ftrap && lg) ? 1 : 0);
        chk("wb_pulses", o_wb, (cause == 0) ? 1 : 0);
        chk("strobe_during_stall", o_stb, 0);
        chk("ibus_req_cycles", o_ir, e_ir);
        chk("dbus_req_cycles", o_dr, e_dr);
        chk("dbus_we_cycles", o_we, e_we);
        chk("retired", retired, exp_q.pop_front());
        if (cause != 0) begin
            chk("trap_state", state_o, 6);
            chk("trap_flag", trap, 1);
            chk("trap_cause", trap_cause, cause);
            trap_clear = 1'b1;
            stall      = ($urandom_range(1) == 1);
            tick();
            trap_clear = 1'b0;
            stall      = 1'b0;
            #1;
            chk("cleared_state", state_o, 0);
            chk("cleared_cause", trap_cause, 0);
            chk("cleared_trap", trap, 0);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, di, dd;
        logic [6:0] op;
        opcode = OP_ALU; stall = 1'b0; debug_wait = 1'b0; trap_clear = 1'b0;
        bus_a.ibus_ack = 1'b1; bus_a.dbus_ack = 1'b0;
        b_opcode = OP_ALUI; b_stall = 1'b0; b_debug_wait = 1'b1; b_trap_clear = 1'b0;
        bus_b.ibus_ack = 1'b1; bus_b.dbus_ack = 1'b0;

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_ibus_req", bus_a.ibus_req, 0);
        chk("rst_dbus_req", bus_a.dbus_req, 0);
        chk("rst_dbus_we", bus_a.dbus_we, 0);
        chk("rst_load_ir", load_ir, 0);
        chk("rst_en_pc", en_pc_counter, 0);
        chk("rst_wb", write_back_stage, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_retired", retired, 0);
        chk("rst_b_state", b_state, 0);
        tick();

        // ALU with ibus_ack tied high: 1,2,3,5 repeating, three retired
        rst = 1'b1;
        #1 chk("idle_after_release", state_o, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
            chk("seq_state", state_o, pat[i % 4]);
            chk("seq_load_ir", load_ir, pat[i % 4] == 3'd2);
            chk("seq_en_pc", en_pc_counter, pat[i % 4] == 3'd3);
            chk("seq_wb", write_back_stage, pat[i % 4] == 3'd5);
        end
        tick();
        #1;
        chk("seq_retired", retired, 3);
        exp_ret = 3;

        run_instr(OP_LOAD, 0, 3, 0, -1, 0, cyc);
        chk("load_total_cycles", cyc, 8);
        run_instr(OP_STORE, 1, 2, 0, -1, 0, cyc);
        chk("store_total_cycles", cyc, 8);
        run_instr(OP_ALU, TO, 0, 0, -1, 0, cyc);
        run_instr(7'b1111111, 0, 0, 0, -1, 0, cyc);
        run_instr(OP_ALUI, 0, 0, 0, 1, 3, cyc);
        chk("stall_total_cycles", cyc, 7);
        run_instr(OP_ALU, TO - 1, 0, 0, -1, 0, cyc);
        run_instr(OP_LOAD, 0, TO - 1, 0, -1, 0, cyc);
        run_instr(OP_LOAD, 0, TO, 0, -1, 0, cyc);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(9) < 8) begin
                op = legal_ops[$urandom_range(8)];
            end else begin
                do op = 7'($urandom_range(127)); while (is_legal(op));
            end
            di = ($urandom_range(9) < 8) ? int'($urandom_range(3)) : int'($urandom_range(6, 4));
            dd = ($urandom_range(9) < 8) ? int'($urandom_range(3)) : int'($urandom_range(6, 4));
            run_instr(op, di, dd, 25, -1, 0, cyc);
        end

        // Asynchronous reset while a fetch is outstanding
        opcode = OP_ALU;
        #1 chk("req_before_reset", bus_a.ibus_req, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_ibus_req", bus_a.ibus_req, 0);
        chk("async_state", state_o, 0);
        chk("async_retired", retired, 0);
        debug_wait = 1'b1;
        tick();
        rst = 1'b1;

        // Fused writeback, 4-bit retire counter wrapping after 16
        b_debug_wait = 1'b0;
        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                #1;
                chk("fuse_state", b_state, c + 1);
                chk("fuse_wb", b_wb, c == 2);
                chk("fuse_load_ir", b_load_ir, c == 1);
                if (c == 0) chk("fuse_retired", b_retired, i % 16);
                if (i == 16 && c == 0) b_debug_wait = 1'b1;
            end
        end
        tick();
        #1;
        chk("fuse_parked", b_state, 0);
        chk("fuse_wrapped", b_retired, 1);
        tick();
        #1;
        chk("fuse_still_parked", b_state, 0);
        chk("a_parked", state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
